// File: rtl/spi_txn_sched.sv
// spi_txn_sched: FIFO-buffered SPI transaction scheduler with start/done main handshake and tagged responses.
// Optional WAIT watchdog enabled by defining SPI_SCHED_TIMEOUT_EN.
module spi_txn_sched #(
   parameter int NUM_NODES = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int LW = AW + 1,
   localparam int GW = $clog2(GAP_CYCLES + 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NW-1:0]         req_node,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [NW-1:0]         rsp_node,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  m_start,
   output logic [NW-1:0]         m_sel,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_done,
   input  logic [DATA_WIDTH-1:0] m_rx_data,
   output logic [LW-1:0]         fifo_level,
   output logic                  idle
);
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("spi_txn_sched: invalid FIFO_DEPTH or TIMEOUT_CYCLES");
   end
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;
   state_t state, state_d;
   logic [NW+DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [LW-1:0] level_d;
   logic [GW-1:0] gcnt;
   logic [NW-1:0] head_node;
   logic [DATA_WIDTH-1:0] head_data;
   logic push, pop, bad, timeout, finish;
   assign {head_node, head_data} = mem[rp];
   assign push = req_valid & req_ready;
   assign pop = (state == IDLE) && (fifo_level != '0);
   assign bad = 32'(head_node) >= NUM_NODES;
   assign finish = (state == WAIT) && (m_done || timeout);
   assign level_d = fifo_level + LW'(push) - LW'(pop);
   assign m_start = state == ISSUE;
   assign rsp_valid = state == RESP;
`ifdef SPI_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) tcnt <= '0;
      else tcnt <= (state == WAIT) ? tcnt + TW'(1) : '0;
   assign timeout = tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (pop) state_d = bad ? RESP : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (m_done || timeout) state_d = RESP;
         RESP:    if (rsp_ready) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
         GAP:     if (gcnt == GW'(GAP_CYCLES - 1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= {req_node, req_data};
   // Registered ready/idle so both read 0 while reset is held.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         wp <= '0;
         rp <= '0;
         fifo_level <= '0;
         req_ready <= 1'b0;
         idle <= 1'b0;
         gcnt <= '0;
         m_sel <= '0;
         m_data <= '0;
         rsp_node <= '0;
         rsp_data <= '0;
         rsp_err <= 1'b0;
      end else begin
         state <= state_d;
         fifo_level <= level_d;
         req_ready <= level_d != LW'(FIFO_DEPTH);
         idle <= (state_d == IDLE) && (level_d == '0);
         gcnt <= (state == GAP) ? gcnt + GW'(1) : '0;
         if (push) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         if (pop && !bad) begin
            m_sel <= head_node;
            m_data <= head_data;
         end
         if (pop && bad) begin
            rsp_node <= head_node;
            rsp_data <= '0;
            rsp_err <= 1'b1;
         end
         if (finish) begin
            rsp_node <= m_sel;
            rsp_data <= m_done ? m_rx_data : '0;
            rsp_err <= !m_done;
         end
      end
endmodule

// File: tb/tb_spi_txn_sched.sv
// tb_spi_txn_sched: directed vector bench for spi_txn_sched with a simple main-stage model.
// Main model answers each m_start with m_rx_data = m_data ^ 8'h99 after main_lat cycles.
module tb_spi_txn_sched;
   logic clk = 0, rst = 0;
   logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, m_start, m_done_m = 0, inj = 0, idle;
   logic [1:0] req_node = 0, rsp_node, m_sel;
   logic [7:0] req_data = 0, rsp_data, m_data, m_rx_data = 0, tx = 0;
   logic [2:0] fifo_level;
   logic main_en = 1, pend = 0;
   int checks = 0, errors = 0, starts = 0, main_lat = 3, cnt = 0;

   typedef struct {
      logic [1:0] node;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic exp_err;
   } vec_t;
   vec_t vecs [5];
   vec_t fill [5];

   spi_txn_sched #(.NUM_NODES(3), .DATA_WIDTH(8), .FIFO_DEPTH(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_node(req_node),
      .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_node(rsp_node),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .m_start(m_start), .m_sel(m_sel), .m_data(m_data),
      .m_done(m_done_m | inj), .m_rx_data(m_rx_data), .fifo_level(fifo_level), .idle(idle));

   always #5 clk = ~clk;
   always @(posedge clk) if (m_start) starts++;

   initial forever begin
      @(posedge clk); #1;
      m_done_m = 0;
      if (!rst) pend = 0;
      else if (m_start) begin
         pend = 1;
         cnt = 0;
         tx = m_data;
      end else if (pend && main_en) begin
         cnt++;
         if (cnt >= main_lat) begin
            m_done_m = 1;
            m_rx_data = tx ^ 8'h99;
            pend = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic push(input logic [1:0] n, input logic [7:0] d);
      int t = 0;
      req_node = n;
      req_data = d;
      req_valid = 1;
      while (!req_ready && t < 300) begin
         step(1);
         t++;
      end
      chk("push_ready", 32'(req_ready), 32'd1);
      step(1);
      req_valid = 0;
   endtask

   task automatic get_rsp(input logic [1:0] n, input logic [7:0] d, input logic e, input string tag);
      int t = 0;
      while (!rsp_valid && t < 300) begin
         step(1);
         t++;
      end
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_node"}, 32'(rsp_node), 32'(n));
      chk({tag, "_data"}, 32'(rsp_data), 32'(d));
      chk({tag, "_err"}, 32'(rsp_err), 32'(e));
      rsp_ready = 1;
      step(1);
      rsp_ready = 0;
   endtask

   initial begin
      int s0, n, t;
      logic stable;
      vecs[0] = '{2'd0, 8'h00, 8'h99, 1'b0};
      vecs[1] = '{2'd1, 8'hFF, 8'h66, 1'b0};
      vecs[2] = '{2'd2, 8'h5A, 8'hC3, 1'b0};
      vecs[3] = '{2'd3, 8'h81, 8'h00, 1'b1};
      vecs[4] = '{2'd1, 8'h3C, 8'hA5, 1'b0};
      fill[0] = '{2'd0, 8'h11, 8'h88, 1'b0};
      fill[1] = '{2'd1, 8'h22, 8'hBB, 1'b0};
      fill[2] = '{2'd2, 8'h33, 8'hAA, 1'b0};
      fill[3] = '{2'd0, 8'h44, 8'hDD, 1'b0};
      fill[4] = '{2'd1, 8'h55, 8'hCC, 1'b0};
      // reset state
      step(2);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_idle", 32'(idle), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_m_start", 32'(m_start), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      rst = 1;
      step(1);
      chk("rel_req_ready", 32'(req_ready), 32'd1);
      chk("rel_idle", 32'(idle), 32'd1);
      // single transfer and start latency
      main_lat = 16;
      push(2'd2, 8'hA5);
      chk("lat_start_early", 32'(m_start), 32'd0);
      step(1);
      chk("lat_start", 32'(m_start), 32'd1);
      chk("lat_sel", 32'(m_sel), 32'd2);
      chk("lat_data", 32'(m_data), 32'hA5);
      get_rsp(2'd2, 8'h3C, 1'b0, "single");
      step(4);
      chk("single_idle", 32'(idle), 32'd1);
      // vector table, including a bad node index
      main_lat = 3;
      s0 = starts;
      foreach (vecs[i]) begin
         push(vecs[i].node, vecs[i].data);
         get_rsp(vecs[i].node, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
      end
      chk("vec_starts", 32'(starts - s0), 32'd4);
      // fill/full with main stalled
      main_en = 0;
      foreach (fill[i]) push(fill[i].node, fill[i].data);
      step(2);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_ready", 32'(req_ready), 32'd0);
      main_en = 1;
      foreach (fill[i]) get_rsp(fill[i].node, fill[i].exp_data, fill[i].exp_err, $sformatf("fill%0d", i));
      // response backpressure then gap timing
      main_lat = 4;
      push(2'd2, 8'h10);
      push(2'd0, 8'h20);
      t = 0;
      while (!rsp_valid && t < 300) begin
         step(1);
         t++;
      end
      s0 = starts;
      stable = 1;
      repeat (10) begin
         step(1);
         if (!rsp_valid || rsp_node != 2'd2 || rsp_data != 8'h89 || rsp_err) stable = 0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      chk("bp_no_start", 32'(starts - s0), 32'd0);
      rsp_ready = 1;
      step(1);
      rsp_ready = 0;
      n = 1;
      while (!m_start && n < 20) begin
         step(1);
         n++;
      end
      chk("bp_gap", 32'(n), 32'd4);
      get_rsp(2'd0, 8'hB9, 1'b0, "bp2");
      // reset while a transfer is in WAIT
      main_en = 0;
      push(2'd0, 8'h01);
      push(2'd1, 8'h02);
      push(2'd2, 8'h03);
      step(3);
      chk("wrst_pre_level", 32'(fifo_level), 32'd2);
      rst = 0;
      #1;
      chk("wrst_level", 32'(fifo_level), 32'd0);
      chk("wrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wrst_m_start", 32'(m_start), 32'd0);
      step(2);
      rst = 1;
      step(1);
      chk("wrst_idle", 32'(idle), 32'd1);
      main_en = 1;
      s0 = starts;
      step(30);
      chk("wrst_no_start", 32'(starts - s0), 32'd0);
      chk("wrst_no_rsp", 32'(rsp_valid), 32'd0);
      // stray done outside WAIT
      inj = 1;
      step(1);
      inj = 0;
      step(2);
      chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
      chk("stray_idle", 32'(idle), 32'd1);
`ifdef SPI_SCHED_TIMEOUT_EN
      main_en = 0;
      push(2'd1, 8'h77);
      step(1);
      chk("to_start", 32'(m_start), 32'd1);
      n = 0;
      while (!rsp_valid && n < 200) begin
         step(1);
         n++;
      end
      chk("to_cycles", 32'(n), 32'd51);
      get_rsp(2'd1, 8'h00, 1'b1, "to");
      step(8);
      inj = 1;
      step(1);
      inj = 0;
      step(4);
      chk("to_late_done", 32'(rsp_valid), 32'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_txn_sched.md
Name: spi_txn_sched

Overview:
- Transaction scheduler directly upstream of the SPI main stage.
- Accepts per-node transfer requests (target node index + TX word) over valid/ready and buffers them in a small FIFO.
- Issues requests one at a time to the main stage via a start/done handshake, then returns the received MISO word, tagged with its node index, over a valid/ready response channel.
- Enforces a minimum idle gap between back-to-back transfers so the chip-select decoder sees a clean deselect.

Parameters:
- NUM_NODES, 4, number of SPI nodes addressable through the select decoder.
- DATA_WIDTH, 8, bits per SPI transfer.
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- GAP_CYCLES, 2, minimum clk cycles between done and the next m_start; 0 allowed.
- TIMEOUT_CYCLES, 1024, watchdog limit while waiting for done (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_node  in  $clog2(NUM_NODES)  target node index.
- req_data  in  DATA_WIDTH  word to shift out on MOSI.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_node  out  $clog2(NUM_NODES)  node index of completed transfer.
- rsp_data  out  DATA_WIDTH  word shifted in on MISO.
- rsp_err  out  1  transfer not performed (bad index, or timeout).
- m_start  out  1  single-cycle start pulse to main stage.
- m_sel  out  $clog2(NUM_NODES)  node select to main/decoder; held for the whole transfer.
- m_data  out  DATA_WIDTH  TX word to main; held for the whole transfer.
- m_done  in  1  single-cycle pulse, transfer finished.
- m_rx_data  in  DATA_WIDTH  received word; valid in the m_done cycle.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- idle  out  1  FIFO empty, FSM in IDLE, no pending response.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0; FIFO pointers and level clear; FSM enters IDLE.
  - After release, req_ready=1 and idle=1 on the first clk edge.
  - Reset mid-transfer abandons the transfer; no response is produced.
- FIFO:
  - Write occurs when req_valid & req_ready; req_ready = (level != FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop at full is legal: level is unchanged and req_ready stays 0 that cycle (registered-full semantics).
  - Push at empty is visible to the FSM the next cycle; there is no fall-through.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the m_sel/m_data holding registers.
    - If the head index is >= NUM_NODES, go to RESP with rsp_err=1 and rsp_data=0.
    - Otherwise go to ISSUE.
  - ISSUE: assert m_start for exactly one cycle, then go to WAIT.
  - WAIT: on m_done, capture m_rx_data into rsp_data, set rsp_node=m_sel and rsp_err=0, then go to RESP.
    - An m_done in any state other than WAIT is ignored.
  - RESP: hold rsp_valid=1 and keep rsp_* stable until rsp_ready.
    - On handshake, go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: count GAP_CYCLES clk cycles, then go to IDLE. The FIFO keeps accepting requests during GAP.
- Latency: a request pushed into an empty FIFO while in IDLE produces m_start 2 cycles after the accepting edge.
- Back-to-back spacing: with rsp_ready held high, consecutive m_start pulses are separated by at least transfer length + GAP_CYCLES + 3 cycles.
- m_sel/m_data change only on the IDLE-to-ISSUE transition.
- Ordering: responses come out in strict request order; exactly one response per accepted request.

Optional Feature:
- Macro: SPI_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES with no m_done, go to RESP with rsp_err=1 and rsp_data=0.
  - A late m_done after the timeout is ignored.
- Undefined: no counter is synthesised; WAIT waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Single transfer: push node=2, data=0xA5; main model returns 0x3C after 16 cycles -> m_start 2 cycles after push, m_sel=2, m_data=0xA5; then rsp_valid with rsp_node=2, rsp_data=0x3C, rsp_err=0.
- Fill/full: with main stalled (no m_done), push 5 requests, FIFO_DEPTH=4 -> 1 request in flight, 4 accepted into the FIFO, req_ready=0, fifo_level=4; releasing main drains all 5 responses in order.
- Backpressure: hold rsp_ready=0 for 10 cycles after the first done -> rsp_* stable, no further m_start; on release, next m_start follows after GAP_CYCLES=2 plus 1 cycle.
- Bad index: NUM_NODES=3, push node=3 -> no m_start; response has rsp_err=1, rsp_data=0x00, rsp_node=3.
- Reset in WAIT: assert rst low mid-transfer with 2 requests queued -> fifo_level=0, rsp_valid=0, m_start=0 immediately; idle=1 after release.
- Timeout (SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50): main never pulses done -> rsp_err=1 at cycle 50 of WAIT; an m_done injected at cycle 60 produces no second response.
